// File: rtl/issue.sv
// In-order issue stage: a 4-deep instruction queue fed from instruction
// memory, a 16-entry rename table, and dispatch into an add/sub station (RS1)
// or a mul/div station (RS2) with a matching ROB allocation.
// Optional feature: define ISSUE_STATS_EN to add saturating issue/stall counters.
module issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [3:0]  imem_addr,
  input  logic [15:0] imem_data,
  output logic [3:0]  rf_addr1,
  output logic [3:0]  rf_addr2,
  input  logic [7:0]  rf_data1,
  input  logic [7:0]  rf_data2,
  input  logic        rob_full,
  input  logic [2:0]  rob_tail,
  output logic        rob_alloc,
  output logic [3:0]  rob_op,
  output logic [3:0]  rob_dest,
  output logic [15:0] rob_instr,
  input  logic        rs1_full,
  input  logic        rs2_full,
  output logic        rs1_write,
  output logic        rs2_write,
  output logic [3:0]  rs_op,
  output logic [2:0]  rs_dest_tag,
  output logic        src1_ready,
  output logic        src2_ready,
  output logic [7:0]  src1_val,
  output logic [7:0]  src2_val,
  output logic [2:0]  src1_tag,
  output logic [2:0]  src2_tag,
  input  logic        commit_valid,
  input  logic [3:0]  commit_reg,
  input  logic [2:0]  commit_tag,
  output logic        unsupported
`ifdef ISSUE_STATS_EN
  ,
  output logic [15:0] issued_count,
  output logic [15:0] stall_count
`endif
);

  // Fetch / queue state
  logic [3:0]        pc_q, pc_d;
  logic [1:0]        head_q, head_d;
  logic [1:0]        tail_q, tail_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [15:0]       iq_q [4];

  // Rename table: valid=1 means the architectural register file holds the value
  logic [15:0]       rn_valid_q, rn_valid_d;
  logic [15:0][2:0]  rn_tag_q, rn_tag_d;

  // Head decode
  logic [15:0] head_instr;
  logic [3:0]  op, rd, rs1, rs2;
  logic        have, is_rs1, bad_op, tgt_full, do_issue, do_drop, pop, push;

  assign head_instr = iq_q[head_q];
  assign op         = head_instr[15:12];
  assign rd         = head_instr[11:8];
  assign rs1        = head_instr[7:4];
  assign rs2        = head_instr[3:0];

  assign have     = (cnt_q != 3'd0);
  assign is_rs1   = (op[3:1] == 3'b000);
  assign bad_op   = (op[3:2] != 2'b00);
  assign tgt_full = is_rs1 ? rs1_full : rs2_full;

  // Strobes are gated by rst_n so nothing leaks out during a reset cycle.
  assign do_issue = rst_n && have && !bad_op && !rob_full && !tgt_full;
  assign do_drop  = rst_n && have && bad_op;
  assign pop      = do_issue || do_drop;
  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign push     = rst_n && fetch_en && ((cnt_q < 3'd4) || pop);

  // Outputs
  assign imem_addr   = pc_q;
  assign rf_addr1    = rs1;
  assign rf_addr2    = rs2;
  assign rob_alloc   = do_issue;
  assign rob_op      = op;
  assign rob_dest    = rd;
  assign rob_instr   = head_instr;
  assign rs1_write   = do_issue && is_rs1;
  assign rs2_write   = do_issue && !is_rs1;
  assign rs_op       = op;
  assign rs_dest_tag = rob_tail;
  assign unsupported = do_drop;

  // Sources see the table as it stands before this cycle's rename/commit.
  assign src1_ready  = rn_valid_q[rs1];
  assign src2_ready  = rn_valid_q[rs2];
  assign src1_val    = rf_data1;
  assign src2_val    = rf_data2;
  assign src1_tag    = rn_tag_q[rs1];
  assign src2_tag    = rn_tag_q[rs2];

  // Next-state for pointers, PC, count and rename table
  always_comb begin
    pc_d       = pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    cnt_d      = cnt_q;
    rn_valid_d = rn_valid_q;
    rn_tag_d   = rn_tag_q;
    if (push) begin
      tail_d = tail_q + 2'd1;
      pc_d   = pc_q + 4'd1;
    end
    if (pop) head_d = head_q + 2'd1;
    cnt_d = cnt_q + {2'b00, push} - {2'b00, pop};
    // Commit only retires the mapping if no younger producer has replaced it.
    if (commit_valid && (rn_tag_q[commit_reg] == commit_tag))
      rn_valid_d[commit_reg] = 1'b1;
    // A rename in the same cycle wins over the commit.
    if (do_issue) begin
      rn_valid_d[rd] = 1'b0;
      rn_tag_d[rd]   = rob_tail;
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= 4'd0;
      head_q     <= 2'd0;
      tail_q     <= 2'd0;
      cnt_q      <= 3'd0;
      rn_valid_q <= '1;
      rn_tag_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      rn_valid_q <= rn_valid_d;
      rn_tag_q   <= rn_tag_d;
    end
  end

  // Queue storage; contents are meaningless while count says empty, so no reset
  always_ff @(posedge clk) begin
    if (push) iq_q[tail_q] <= imem_data;
  end

`ifdef ISSUE_STATS_EN
  logic [15:0] issued_q, stall_q;
  logic        stall;

  assign stall = rst_n && have && !bad_op && (rob_full || tgt_full);

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issued_q <= 16'd0;
      stall_q  <= 16'd0;
    end else begin
      if (do_issue && (issued_q != 16'hFFFF)) issued_q <= issued_q + 16'd1;
      if (stall && (stall_q != 16'hFFFF))     stall_q  <= stall_q + 16'd1;
    end
  end

  assign issued_count = issued_q;
  assign stall_count  = stall_q;
`endif

endmodule

// File: tb/tb_issue.sv
// Bench for issue: directed scenarios followed by randomized traffic, with
// every cycle checked against a queue-based reference model.
module tb_issue;
  logic        clk = 1'b0;
  logic        rst_n, fetch_en;
  logic [3:0]  imem_addr;
  logic [15:0] imem_data;
  logic [3:0]  rf_addr1, rf_addr2;
  logic [7:0]  rf_data1, rf_data2;
  logic        rob_full;
  logic [2:0]  rob_tail;
  logic        rob_alloc;
  logic [3:0]  rob_op, rob_dest;
  logic [15:0] rob_instr;
  logic        rs1_full, rs2_full, rs1_write, rs2_write;
  logic [3:0]  rs_op;
  logic [2:0]  rs_dest_tag;
  logic        src1_ready, src2_ready;
  logic [7:0]  src1_val, src2_val;
  logic [2:0]  src1_tag, src2_tag;
  logic        commit_valid;
  logic [3:0]  commit_reg;
  logic [2:0]  commit_tag;
  logic        unsupported;
`ifdef ISSUE_STATS_EN
  logic [15:0] issued_count, stall_count;
`endif

  logic [15:0] mem  [16];
  logic [7:0]  regs [16];
  assign imem_data = mem[imem_addr];
  assign rf_data1  = regs[rf_addr1];
  assign rf_data2  = regs[rf_addr2];

  always #5 clk = ~clk;

  issue dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .rob_full(rob_full), .rob_tail(rob_tail),
    .rob_alloc(rob_alloc), .rob_op(rob_op), .rob_dest(rob_dest), .rob_instr(rob_instr),
    .rs1_full(rs1_full), .rs2_full(rs2_full),
    .rs1_write(rs1_write), .rs2_write(rs2_write),
    .rs_op(rs_op), .rs_dest_tag(rs_dest_tag),
    .src1_ready(src1_ready), .src2_ready(src2_ready),
    .src1_val(src1_val), .src2_val(src2_val),
    .src1_tag(src1_tag), .src2_tag(src2_tag),
    .commit_valid(commit_valid), .commit_reg(commit_reg), .commit_tag(commit_tag),
    .unsupported(unsupported)
`ifdef ISSUE_STATS_EN
    , .issued_count(issued_count), .stall_count(stall_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: architectural view of queue, PC and rename table
  logic [15:0] mq[$];
  int          mpc = 0;
  bit          mval [16];
  int          mtag [16];
  int          n_alloc = 0;
  bit          mon_en = 1'b0;
  int          m_isc = 0, m_stc = 0;

  initial for (int i = 0; i < 16; i++) begin mval[i] = 1'b1; mtag[i] = 0; end

  // Check outputs mid-cycle, then advance the model to the post-edge state
  always @(negedge clk) begin
    logic [15:0] h;
    int  op, r1, r2, rdx;
    bit  have, unsup, full, iss, pop, push;
    if (mon_en) begin
      have  = mq.size() > 0;
      h     = have ? mq[0] : 16'h0;
      op    = int'(h[15:12]);
      rdx   = int'(h[11:8]);
      r1    = int'(h[7:4]);
      r2    = int'(h[3:0]);
      unsup = have && (op > 3);
      full  = (op < 2) ? rs1_full : rs2_full;
      iss   = rst_n && have && !unsup && !rob_full && !full;
      if (rob_alloc) n_alloc++;

      chk("pc", imem_addr, mpc);
      chk("alloc", rob_alloc, iss);
      chk("rs1w", rs1_write, iss && (op < 2));
      chk("rs2w", rs2_write, iss && (op >= 2));
      chk("unsup", unsupported, rst_n && unsup);
      if (iss) begin
        chk("rob_op", rob_op, op);
        chk("rob_dest", rob_dest, rdx);
        chk("rob_instr", rob_instr, h);
        chk("rs_op", rs_op, op);
        chk("dtag", rs_dest_tag, rob_tail);
        chk("s1rdy", src1_ready, mval[r1]);
        chk("s2rdy", src2_ready, mval[r2]);
        if (mval[r1]) chk("s1val", src1_val, regs[r1]); else chk("s1tag", src1_tag, mtag[r1]);
        if (mval[r2]) chk("s2val", src2_val, regs[r2]); else chk("s2tag", src2_tag, mtag[r2]);
      end
`ifdef ISSUE_STATS_EN
      chk("issued_cnt", issued_count, m_isc);
      chk("stall_cnt", stall_count, m_stc);
`endif
      if (!rst_n) begin
        mq.delete();
        mpc = 0;
        for (int i = 0; i < 16; i++) begin mval[i] = 1'b1; mtag[i] = 0; end
        m_isc = 0; m_stc = 0;
      end else begin
        pop  = iss || unsup;
        push = fetch_en && ((mq.size() < 4) || pop);
        if (iss && m_isc < 65535) m_isc++;
        if (have && !unsup && (rob_full || full) && m_stc < 65535) m_stc++;
        if (commit_valid && mtag[commit_reg] == int'(commit_tag)) mval[commit_reg] = 1'b1;
        if (iss) begin mval[rdx] = 1'b0; mtag[rdx] = int'(rob_tail); end
        if (pop) void'(mq.pop_front());
        if (push) begin mq.push_back(mem[mpc]); mpc = (mpc + 1) % 16; end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a0;
    rst_n = 1'b0; fetch_en = 1'b0; rob_full = 1'b0; rs1_full = 1'b0; rs2_full = 1'b0;
    rob_tail = 3'd0; commit_valid = 1'b0; commit_reg = 4'd0; commit_tag = 3'd0;
    for (int i = 0; i < 16; i++) begin regs[i] = 8'h02; mem[i] = 16'h0000; end
    mem[0] = 16'h1123; mem[1] = 16'h2415; mem[2] = 16'h0010; mem[3] = 16'h0010;
    mem[4] = 16'h1321; mem[5] = 16'h2456; mem[6] = 16'h0789; mem[7] = 16'h3abc;

    step(); mon_en = 1'b1;
    #2 chk("rst_alloc0", rob_alloc, 0);
    step(); rst_n = 1'b1; fetch_en = 1'b1;
    #2 chk("c1_alloc", rob_alloc, 0);
    // First instruction issues on the second cycle after reset release
    step();
    #2 chk("c2_alloc", rob_alloc, 1); chk("c2_rs1w", rs1_write, 1); chk("c2_op", rs_op, 1);
    chk("c2_v1", src1_val, 8'h02); chk("c2_v2", src2_val, 8'h02); chk("c2_dtag", rs_dest_tag, 0);
    // Dependent mul reads r1 which is now renamed to tag 0
    step(); fetch_en = 1'b0; rob_tail = 3'd1;
    #2 chk("c3_rs2w", rs2_write, 1); chk("c3_s1rdy", src1_ready, 0);
    chk("c3_s1tag", src1_tag, 0); chk("c3_s2rdy", src2_ready, 1);
    // Stale commit (tag 5) must not validate r1
    step(); rob_tail = 3'd2; commit_valid = 1'b1; commit_reg = 4'd1; commit_tag = 3'd5; fetch_en = 1'b1;
    step(); commit_tag = 3'd0;
    #2 chk("c5_alloc", rob_alloc, 1); chk("c5_s1rdy", src1_ready, 0);
    step(); commit_valid = 1'b0; fetch_en = 1'b0; rob_tail = 3'd3;
    #2 chk("c6_s1rdy", src1_ready, 1); chk("c6_s1val", src1_val, 8'h02);
    // ROB full for five cycles while fetch fills the queue
    step(); rob_full = 1'b1; fetch_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2 chk("stall_alloc", rob_alloc, 0);
      step();
    end
    rob_full = 1'b0;
    #2 chk("rel_alloc", rob_alloc, 1); chk("rel_pc", imem_addr, 8);
    // Reset while the queue is full and fetch is running
    step(); rst_n = 1'b0;
    #2 chk("midrst_alloc", rob_alloc, 0); chk("midrst_unsup", unsupported, 0);
    step(); rst_n = 1'b1; mem[0] = 16'h5123; mem[1] = 16'h1234;
    #2 chk("r_c1_alloc", rob_alloc, 0);
    step();
    #2 chk("bad_unsup", unsupported, 1); chk("bad_alloc", rob_alloc, 0);
    step();
    #2 chk("after_bad_alloc", rob_alloc, 1); chk("after_bad_unsup", unsupported, 0);
    chk("after_bad_instr", rob_instr, 16'h1234);
    // Back-to-back issue long enough to wrap PC and queue pointers
    for (int i = 0; i < 16; i++) mem[i] = {2'b00, 2'($urandom_range(0, 3)), 12'($urandom)};
    step();
    a0 = n_alloc;
    for (int i = 0; i < 24; i++) begin rob_tail = 3'($urandom); step(); end
    chk("wrap_issues", n_alloc - a0, 24);
    // Fully randomized traffic
    for (int i = 0; i < 16; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? {4'($urandom_range(4, 15)), 12'($urandom)}
                                            : {2'b00, 2'($urandom_range(0, 3)), 12'($urandom)};
    for (int c = 0; c < 400; c++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      fetch_en  = ($urandom_range(0, 3) != 0);
      rob_full  = ($urandom_range(0, 4) == 0);
      rs1_full  = ($urandom_range(0, 3) == 0);
      rs2_full  = ($urandom_range(0, 3) == 0);
      rob_tail  = 3'($urandom);
      commit_valid = $urandom_range(0, 1) == 1;
      commit_reg   = 4'($urandom);
      commit_tag   = ($urandom_range(0, 1) == 1) ? 3'(mtag[commit_reg]) : 3'($urandom);
      if ($urandom_range(0, 7) == 0) regs[$urandom_range(0, 15)] = 8'($urandom);
      if ($urandom_range(0, 15) == 0) mem[$urandom_range(0, 15)] = 16'($urandom);
      step();
    end
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
